// File: rtl/pdp8i_timing_pkg.sv
// Shared definitions for the PDP-8/I major-cycle timing sequencer:
// state encoding, time-state/time-pulse bit indices and the default
// number of clocks per time state.
package pdp8i_timing_pkg;

  // 8 clocks per time state gives 375 ns at a 21.33 MHz clock.
  localparam int TS_CLKS_DEFAULT = 8;

  // Bit positions of TS1..TS4 in ts and TP1..TP4 in tp.
  localparam int TS1_IDX = 0;
  localparam int TS2_IDX = 1;
  localparam int TS3_IDX = 2;
  localparam int TS4_IDX = 3;

  // One-hot encoding lines up bit-for-bit with the ts output, so the
  // state register drives ts directly with no decode.
  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    TS1  = 4'b0001,
    TS2  = 4'b0010,
    TS3  = 4'b0100,
    TS4  = 4'b1000
  } ts_state_e;

endpackage

// File: rtl/ts_slot_counter.sv
// Intra-time-state clock counter. Counts 0..TS_CLKS-1 and never wraps:
// it sits at the terminal count until cleared. hold_i freezes it for
// IOT pause and memory handshake waits.
module ts_slot_counter #(
  parameter int TS_CLKS = 8,
  parameter int CNT_W   = $clog2(TS_CLKS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic hold_i,
  output logic tc_o,
  output logic pre_tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TS_CLKS - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(TS_CLKS - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless holding or already at the end.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o     = (cnt_q == LAST);
  assign pre_tc_o = (cnt_q == PRE);

endmodule

// File: rtl/timing_state_gen.sv
// Major-cycle timing sequencer for the PDP-8/I. Splits each memory cycle
// into TS1..TS4 of TS_CLKS clocks each and emits one-clock TP1..TP4 on the
// last clock of each time state. Handles start / run / stop / single-cycle
// sequencing and the IOT pause stretch of TS3.
//
// Build option: define MEM_HANDSHAKE_EN to make TS2 wait for mem_done
// instead of using a fixed count.
//
// Handshake semantics (mem_done, iot_pause): a level sampled on a rising
// edge. The edge that would raise TP2/TP3 raises it only if the wait
// condition is clear at that edge; otherwise the counter sits at its
// terminal value and each following edge re-tests, and the pulse appears
// after the first edge that sees the condition clear. The state advances
// on the edge after the pulse.
module timing_state_gen
  import pdp8i_timing_pkg::*;
#(
  parameter int TS_CLKS = TS_CLKS_DEFAULT,
  parameter int CNT_W   = $clog2(TS_CLKS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       start,
  input  logic       stop_req,
  input  logic       single_cycle,
  input  logic       iot_pause,
  input  logic       mem_done,
  output logic [3:0] ts,
  output logic [3:0] tp,
  output logic       mem_start,
  output logic       cycle_end,
  output logic       running
);

  ts_state_e  state_q;
  logic [3:0] tp_q;
  logic       mem_start_q;

  logic       tc;
  logic       pre_tc;
  logic       pulse_done;
  logic       tp_block;
  logic       fire;
  logic       mem_wait;
  logic       cnt_clr;
  logic       cnt_hold;

`ifdef MEM_HANDSHAKE_EN
  assign mem_wait = !mem_done;
`else
  // Core timing is emulated by count; mem_done is not used.
  logic unused_mem_done;
  assign unused_mem_done = mem_done;
  assign mem_wait        = 1'b0;
`endif

  // The pulse of the current time state has already been issued: state and
  // tp share one-hot bit positions.
  assign pulse_done = |(tp_q & state_q);

  // Conditions that suppress the time pulse of the current state.
  always_comb begin
    tp_block = 1'b0;
    case (state_q)
      TS2:     tp_block = mem_wait;
      TS3:     tp_block = iot_pause;
      default: tp_block = 1'b0;
    endcase
  end

  // Raise the pulse on the step into the last count, or later while waiting.
  assign fire = (state_q != IDLE) && !tp_block && (pre_tc || (tc && !pulse_done));

  // Clear between states and while idle; freeze at terminal count while waiting.
  assign cnt_clr  = (state_q == IDLE) || (tc && pulse_done);
  assign cnt_hold = tc && !pulse_done;

  ts_slot_counter #(
    .TS_CLKS (TS_CLKS),
    .CNT_W   (CNT_W)
  ) u_slot_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .hold_i   (cnt_hold),
    .tc_o     (tc),
    .pre_tc_o (pre_tc)
  );

  // Time-state FSM with registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tp_q        <= '0;
      mem_start_q <= 1'b0;
    end else begin
      tp_q        <= '0;
      mem_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= TS1;
            mem_start_q <= 1'b1;
          end
        end
        TS1: begin
          if (tc && pulse_done)  state_q          <= TS2;
          else if (fire)         tp_q[TS1_IDX]    <= 1'b1;
        end
        TS2: begin
          if (tc && pulse_done)  state_q          <= TS3;
          else if (fire)         tp_q[TS2_IDX]    <= 1'b1;
        end
        TS3: begin
          if (tc && pulse_done)  state_q          <= TS4;
          else if (fire)         tp_q[TS3_IDX]    <= 1'b1;
        end
        TS4: begin
          if (tc && pulse_done) begin
            // Run controls matter only here, on the edge closing the TP4 clock.
            if (run && !stop_req && !single_cycle) begin
              state_q     <= TS1;
              mem_start_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
            end
          end else if (fire) begin
            tp_q[TS4_IDX] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ts        = state_q;
  assign tp        = tp_q;
  assign mem_start = mem_start_q;
  assign cycle_end = tp_q[TS4_IDX];
  assign running   = (state_q != IDLE);

endmodule

// File: tb/tb_timing_state_gen.sv
// Bench for timing_state_gen. Each scenario is a per-edge table of input
// levels; a timeline model derives from it when each time state begins and
// ends and where every pulse lands, producing one expected output record per
// edge. The driver pushes that record as it applies the inputs and a
// separate monitor pops and compares just after every rising edge.
// Edge numbering: edge e samples the inputs of table row e; record e is the
// output seen just after edge e. Start is placed in row 1 so TS1 appears
// after edge 1.
module tb_timing_state_gen;

  localparam int K    = 8;
  localparam int MAXL = 200;
  localparam int W    = 27;   // {edge[15:0], ts[3:0], tp[3:0], ms, ce, run}

`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, start, stop_req, single_cycle, iot_pause, mem_done;
  logic [3:0] ts, tp;
  logic       mem_start, cycle_end, running;

  bit         st_a    [MAXL];
  bit         run_a   [MAXL];
  bit         stop_a  [MAXL];
  bit         sc_a    [MAXL];
  bit         pause_a [MAXL];
  bit         md_a    [MAXL];
  logic [10:0] rec_a  [MAXL];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  timing_state_gen #(.TS_CLKS(K)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .start        (start),
    .stop_req     (stop_req),
    .single_cycle (single_cycle),
    .iot_pause    (iot_pause),
    .mem_done     (mem_done),
    .ts           (ts),
    .tp           (tp),
    .mem_start    (mem_start),
    .cycle_end    (cycle_end),
    .running      (running)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Timeline reference model: walks from one start to the next, placing
  // each time state as a span of edges and its pulse on the span's last edge.
  function automatic void build_model(input int len);
    int e, s, t;
    bit cont;
    for (int i = 0; i < MAXL; i++) rec_a[i] = '0;
    e = 0;
    while (e < len) begin
      if (!st_a[e]) begin
        e++;
      end else begin
        s = e;
        cont = 1'b1;
        while (cont) begin
          rec_a[s][2] = 1'b1;                       // mem_start on TS1 entry
          for (int p = 0; p < 4 && s < len; p++) begin
            t = s + K - 1;
            if (p == 1 && HS) while (t < len && !md_a[t]) t++;
            if (p == 2)       while (t < len && pause_a[t]) t++;
            for (int x = s; x <= t && x < len; x++) rec_a[x][7+p] = 1'b1;
            if (t < len) begin
              rec_a[t][3+p] = 1'b1;
              if (p == 3) rec_a[t][1] = 1'b1;
            end
            s = t + 1;
          end
          if (s >= len) begin
            cont = 1'b0;
            e = len;
          end else if (run_a[s] && !stop_a[s] && !sc_a[s]) begin
            cont = 1'b1;                            // back-to-back cycle
          end else begin
            cont = 1'b0;
            e = s + 1;                              // start on the exit edge is ignored
          end
        end
      end
    end
    for (int i = 0; i < MAXL; i++) rec_a[i][0] = |rec_a[i][10:7];
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < MAXL; i++) begin
      st_a[i] = 1'b0; run_a[i] = 1'b1; stop_a[i] = 1'b0;
      sc_a[i] = 1'b0; pause_a[i] = 1'b0; md_a[i] = 1'b1;
    end
  endtask

  // Driver: apply row e before edge e and queue its expected record.
  task automatic run_scen(input int len);
    build_model(len);
    for (int e = 0; e < len; e++) begin
      @(negedge clk);
      start = st_a[e]; run = run_a[e]; stop_req = stop_a[e];
      single_cycle = sc_a[e]; iot_pause = pause_a[e]; mem_done = md_a[e];
      exp_q.push_back({16'(e), rec_a[e]});
    end
    @(negedge clk);
    start = 1'b0; run = 1'b0; stop_req = 1'b0;
    single_cycle = 1'b0; iot_pause = 1'b0; mem_done = 1'b0;
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the DUT against the oldest expected record after each edge.
  task automatic monitor();
    logic [W-1:0] item;
    logic [10:0]  act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        act  = {ts, tp, mem_start, cycle_end, running};
        n_checks++;
        if (act !== item[10:0]) begin
          n_fail++;
          $display("FAIL edge_check edge %0d: got ts=%b tp=%b ms=%b ce=%b run=%b, want ts=%b tp=%b ms=%b ce=%b run=%b",
                   item[26:11], ts, tp, mem_start, cycle_end, running,
                   item[10:7], item[6:3], item[2], item[1], item[0]);
        end
      end
    end
  endtask

  initial begin
    int pc;
    rst_n = 1'b0;
    start = 1'b0; run = 1'b0; stop_req = 1'b0;
    single_cycle = 1'b0; iot_pause = 1'b0; mem_done = 1'b0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ts, tp, mem_start, cycle_end, running} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, want 0", {ts, tp, mem_start, cycle_end, running});
    end
    rst_n = 1'b1;

    // Continuous run with stray starts at 5 and 20, stop requested later.
    clear_tables();
    st_a[1] = 1'b1; st_a[5] = 1'b1; st_a[20] = 1'b1;
    for (int e = 40; e < MAXL; e++) stop_a[e] = 1'b1;
    run_scen(80);

    // Single cycle.
    clear_tables();
    st_a[1] = 1'b1;
    for (int e = 0; e < MAXL; e++) sc_a[e] = 1'b1;
    run_scen(50);

    // Stop raised during TS2.
    clear_tables();
    st_a[1] = 1'b1;
    for (int e = 10; e < MAXL; e++) stop_a[e] = 1'b1;
    run_scen(50);

    // IOT pause stretches TS3.
    clear_tables();
    st_a[1] = 1'b1;
    for (int e = 16; e <= 28; e++) pause_a[e] = 1'b1;
    for (int e = 40; e < MAXL; e++) stop_a[e] = 1'b1;
    run_scen(90);

    // Memory handshake: mem_done low until edge 22.
    clear_tables();
    st_a[1] = 1'b1;
    for (int e = 0; e < MAXL; e++) sc_a[e] = 1'b1;
    for (int e = 0; e < 22; e++) md_a[e] = 1'b0;
    run_scen(60);

    // Randomized scenarios; the tail forces the sequencer back to idle.
    for (int r = 0; r < 6; r++) begin
      clear_tables();
      pc = 0;
      for (int e = 0; e < 150; e++) begin
        st_a[e]   = ($urandom_range(0, 19) == 0);
        run_a[e]  = ($urandom_range(0, 9) != 0);
        stop_a[e] = ($urandom_range(0, 29) == 0);
        sc_a[e]   = ($urandom_range(0, 24) == 0);
        md_a[e]   = ($urandom_range(0, 2) != 0);
        if (pc > 0) begin
          pause_a[e] = 1'b1;
          pc--;
        end else if ($urandom_range(0, 15) == 0) begin
          pause_a[e] = 1'b1;
          pc = $urandom_range(1, 12);
        end
        if (e >= 90) begin
          st_a[e] = 1'b0; pause_a[e] = 1'b0; md_a[e] = 1'b1; stop_a[e] = 1'b1;
        end
      end
      st_a[1] = 1'b1;
      run_scen(150);
    end

    // Asynchronous reset in the middle of TS2.
    clear_tables();
    st_a[1] = 1'b1;
    run_scen(14);
    n_checks++;
    if (ts !== 4'b0010 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_ts: got ts=%b run=%b, want ts=0010 run=1", ts, running);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ts, tp, mem_start, cycle_end, running} !== 11'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b, want 0", {ts, tp, mem_start, cycle_end, running});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: stays idle without start, then runs normally.
    clear_tables();
    run_scen(20);
    clear_tables();
    st_a[1] = 1'b1;
    for (int e = 30; e < MAXL; e++) stop_a[e] = 1'b1;
    run_scen(50);

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
